mko_int_ctrl: RTL and testbench
===============================

Name: mko_int_ctrl

Overview:
Interrupt collector for the five MKO channel controllers. It samples the asynchronous MKO_INT[4:0] lines, captures each rising event into a sticky pending bit, and applies a per-channel mask. It drives one combined interrupt request to the host. It also serves the MKO_INT_REG local-bus register window (select 3'b101), returning read data and an ack-set strobe to the bus slave top.

Parameters:
WB_DATA_WIDTH, 16, local bus data width
WB_ADDR_WIDTH, 16, local bus address width
MKO_INT_REG, 3'b101, block select code compared against Adr_slave_i_lbus_reg[15:13]
INT_ACTIVE_HIGH, 1, 1 = MKO_INT asserted high; 0 = asserted low (inverted after sync)

Ports:
CLK_32  in  1  system clock, 32 MHz
RESET  in  1  synchronous, active-high reset
MKO_INT  in  5  asynchronous interrupt lines from MKO channels 0..4
Adr_slave_i_lbus_reg  in  16  latched bus address
We_slave_i_lbus_reg  in  1  latched write enable (1 = write)
ack_access_str  in  1  one-cycle access strobe from the bus slave
Dat_slave_io_lbus  in  16  bus write data (valid while ack_access_str)
Dat_int_o  out  16  read data for the bus read mux
ack_set_int  out  1  access-accepted flag, feeds the Ack OR-tree
IRQ_MKO  out  1  combined interrupt request, active high

Behaviour:
- Reset (RESET=1 on a CLK_32 edge) clears sync flops, pending, overrun, IRQ_MKO, Dat_int_o and ack_set_int to 0. Mask resets to 5'b11111 (all enabled). Reset wins over every other event in the same cycle.
- Sync: 2-flop synchronizer per line, then a third flop for edge detect. Apply the polarity inversion if INT_ACTIVE_HIGH=0. An event is a rising edge of the normalized level. Latency from the pin to the pending bit is 3 clocks.
- pending[i]: set on event i. Cleared by a write to CLR with bit i=1. Event and clear in the same cycle: pending stays 1 (event wins).
- overrun[i]: set when event i occurs while pending[i] is already 1. Cleared by a CLR write with bit i+8=1. Event and clear in the same cycle: overrun stays 1.
- IRQ_MKO: registered OR of (pending & mask). It asserts 1 clock after pending is set. It deasserts 1 clock after the last enabled pending bit clears or is masked.
- Address hit: ack_access_str=1 and Adr_slave_i_lbus_reg[15:13]==MKO_INT_REG. Sub-register is Adr_slave_i_lbus_reg[1:0].
- Register map (bits not listed read 0, writes ignored):
  - 0 STAT, R: [4:0] pending, [12:8] overrun.
  - 1 MASK, R/W: [4:0] mask.
  - 2 CLR, W: [4:0] clear pending, [12:8] clear overrun; reads 0.
  - 3 RAW, R: [4:0] synchronized normalized levels.
  - Writes to STAT and RAW are ignored but still acked.
- Access FSM with states IDLE, ACK.
  - IDLE: on an address hit, go to ACK. On a read, latch the selected register into Dat_int_o in the same edge. On a write, perform the register update in the same edge. Set ack_set_int=1.
  - ACK: hold ack_set_int=1 and Dat_int_o stable. Return to IDLE and clear ack_set_int when ack_access_str=0 and no hit is present.
  - A second hit while in ACK re-executes the access and stays in ACK.
  - A non-hit strobe leaves the FSM in IDLE and ack_set_int=0.
- Read data is a snapshot taken at the strobe edge. An event arriving in that same cycle is not in the snapshot but is captured in pending.
- Dat_int_o holds its last value in IDLE. The top's read mux qualifies it with ack_set_int.
- Reset mid-access: FSM returns to IDLE, ack_set_int=0, and no register write takes effect.

Test Plan:
- Reset: pulse RESET for 2 clocks -> IRQ_MKO=0, STAT read=16'h0000, MASK read=16'h001F, ack_set_int=1 one clock after the strobe.
- Single event: MKO_INT[2] 0->1 -> pending[2]=1 after 3 clocks, IRQ_MKO=1 on the 4th; STAT read=16'h0004.
- Overrun: MKO_INT[0] pulses twice without a clear -> STAT=16'h0101. Write CLR 16'h0101 -> STAT=16'h0000, IRQ_MKO drops 1 clock later.
- Mask: write MASK 16'h001E, then event on ch0 -> pending[0]=1, IRQ_MKO stays 0. Write MASK 16'h001F -> IRQ_MKO=1 next clock.
- Collision: event on ch3 in the same cycle as CLR write 16'h0008 -> pending[3] remains 1 and IRQ_MKO stays 1.
- Polarity and RAW: INT_ACTIVE_HIGH=0, MKO_INT=5'b11110 -> RAW read=16'h0001 and pending[0] set on the falling pin edge. Strobe with select 3'b100 -> ack_set_int stays 0.

Source files
------------

// File: rtl/mko_int_ctrl.sv
// Interrupt collector for the five MKO channels: synchronises the lines, latches
// rising events into sticky pending/overrun bits and serves the MKO_INT_REG window.
module mko_int_ctrl #(
  parameter int         WB_DATA_WIDTH   = 16,
  parameter int         WB_ADDR_WIDTH   = 16,
  parameter logic [2:0] MKO_INT_REG     = 3'b101,
  parameter int         INT_ACTIVE_HIGH = 1
) (
  input  logic                     CLK_32,
  input  logic                     RESET,
  input  logic [4:0]               MKO_INT,
  input  logic [WB_ADDR_WIDTH-1:0] Adr_slave_i_lbus_reg,
  input  logic                     We_slave_i_lbus_reg,
  input  logic                     ack_access_str,
  input  logic [WB_DATA_WIDTH-1:0] Dat_slave_io_lbus,
  output logic [WB_DATA_WIDTH-1:0] Dat_int_o,
  output logic                     ack_set_int,
  output logic                     IRQ_MKO
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               sync1_q, sync2_q, sync3_q;
  logic [4:0]               pend_q, pend_d;
  logic [4:0]               ovr_q, ovr_d;
  logic [4:0]               mask_q, mask_d;
  logic                     irq_q, irq_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

  logic [4:0]               lvl, lvl_prev, evt;
  logic [4:0]               clr_pend, clr_ovr;
  logic [WB_DATA_WIDTH-1:0] rd_word;
  logic                     hit, wr, rd;
  logic [1:0]               sub;
  logic                     unused_bits;

  // Polarity is normalised after the synchroniser so the edge detector always looks for 0->1.
  assign lvl      = (INT_ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;
  assign lvl_prev = (INT_ACTIVE_HIGH != 0) ? sync3_q : ~sync3_q;
  assign evt      = lvl & ~lvl_prev;

  // Bus handshake: an access is a one-cycle ack_access_str with a matching block select.
  // The access executes on that edge; ack_set_int then stays high until the strobe is gone
  // and no new hit is pending, and Dat_int_o is only meaningful while ack_set_int is high.
  assign hit = ack_access_str &&
               (Adr_slave_i_lbus_reg[WB_ADDR_WIDTH-1 -: 3] == MKO_INT_REG);
  assign sub = Adr_slave_i_lbus_reg[1:0];
  assign wr  = hit && We_slave_i_lbus_reg;
  assign rd  = hit && !We_slave_i_lbus_reg;

  assign unused_bits = ^{Adr_slave_i_lbus_reg[WB_ADDR_WIDTH-4:2],
                         Dat_slave_io_lbus[WB_DATA_WIDTH-1:13],
                         Dat_slave_io_lbus[7:5]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     if (!hit && !ack_access_str) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_word  = '0;
    clr_pend = '0;
    clr_ovr  = '0;
    mask_d   = mask_q;
    case (sub)
      2'd0: begin
        rd_word[4:0]  = pend_q;
        rd_word[12:8] = ovr_q;
      end
      2'd1:    rd_word[4:0] = mask_q;
      2'd3:    rd_word[4:0] = lvl;
      default: rd_word = '0;
    endcase
    if (wr && sub == 2'd1) mask_d = Dat_slave_io_lbus[4:0];
    if (wr && sub == 2'd2) begin
      clr_pend = Dat_slave_io_lbus[4:0];
      clr_ovr  = Dat_slave_io_lbus[12:8];
    end
    dat_d  = rd ? rd_word : dat_q;
    // New events are OR-ed in after the clear so a same-cycle event survives the clear.
    ovr_d  = (ovr_q & ~clr_ovr) | (evt & pend_q);
    pend_d = (pend_q & ~clr_pend) | evt;
    irq_d  = |(pend_q & mask_q);
  end

  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      mask_q  <= 5'b11111;
      irq_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= MKO_INT;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
      dat_q   <= dat_d;
    end
  end

  assign Dat_int_o   = dat_q;
  assign ack_set_int = (state_q == ACK);
  assign IRQ_MKO     = irq_q;

endmodule

// File: tb/tb_mko_int_ctrl.sv
// Bench for mko_int_ctrl: directed steps plus a random phase, checked against a
// pin-history reference model; a second, active-low instance covers polarity.
module tb_mko_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  pins0, pins1;
  logic [15:0] adr, wdat;
  logic        we, stb;
  logic [15:0] dat0, dat1;
  logic        ack0, ack1, irq0, irq1;

  int n_checks = 0;
  int n_fail   = 0;

  always #15 clk = ~clk;

  mko_int_ctrl dut0 (
    .CLK_32(clk), .RESET(rst), .MKO_INT(pins0),
    .Adr_slave_i_lbus_reg(adr), .We_slave_i_lbus_reg(we),
    .ack_access_str(stb), .Dat_slave_io_lbus(wdat),
    .Dat_int_o(dat0), .ack_set_int(ack0), .IRQ_MKO(irq0)
  );

  mko_int_ctrl #(.INT_ACTIVE_HIGH(0)) dut1 (
    .CLK_32(clk), .RESET(rst), .MKO_INT(pins1),
    .Adr_slave_i_lbus_reg(adr), .We_slave_i_lbus_reg(we),
    .ack_access_str(stb), .Dat_slave_io_lbus(wdat),
    .Dat_int_o(dat1), .ack_set_int(ack1), .IRQ_MKO(irq1)
  );

  // Reference model for dut0: hist[k] is the pin vector sampled k+1 edges ago.
  // An event is a level that has been through two flops and was low one edge earlier.
  logic [4:0]  m_pend, m_ovr, m_mask;
  logic        m_irq;
  logic [15:0] m_rdata;
  logic [4:0]  hist [3];

  always @(posedge clk) begin
    logic [4:0]  ev, clrp, clro;
    logic        m_hit;
    logic [15:0] snap;
    if (rst) begin
      m_pend = '0; m_ovr = '0; m_mask = 5'h1F; m_irq = 1'b0; m_rdata = '0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
    end else begin
      m_hit = stb && (adr[15:13] == 3'b101);
      ev    = hist[1] & ~hist[2];
      case (adr[1:0])
        2'd0:    snap = {3'b000, m_ovr, 3'b000, m_pend};
        2'd1:    snap = {11'd0, m_mask};
        2'd3:    snap = {11'd0, hist[1]};
        default: snap = 16'h0000;
      endcase
      if (m_hit && !we) m_rdata = snap;
      clrp = '0; clro = '0;
      if (m_hit && we && adr[1:0] == 2'd2) begin clrp = wdat[4:0]; clro = wdat[12:8]; end
      m_irq = |(m_pend & m_mask);
      if (m_hit && we && adr[1:0] == 2'd1) m_mask = wdat[4:0];
      m_ovr  = (m_ovr & ~clro) | (ev & m_pend);
      m_pend = (m_pend & ~clrp) | ev;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pins0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock, then IRQ is compared with the model.
  task automatic tick();
    @(posedge clk); #1;
    chk("irq_model", {15'd0, irq0}, {15'd0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called #1 after an edge: strobe is sampled on the next edge.
  task automatic bus(input logic w, input logic [1:0] s, input logic [15:0] d,
                     input logic [2:0] sel, output logic [15:0] r);
    stb = 1'b1; we = w; adr = {sel, 11'd0, s}; wdat = d;
    tick();
    stb = 1'b0; we = 1'b0;
    r = dat0;
    chk("ack_during", {15'd0, ack0}, {15'd0, (sel == 3'b101)});
    tick();
    chk("ack_after", {15'd0, ack0}, 16'd0);
  endtask

  task automatic wr_reg(input logic [1:0] s, input logic [15:0] d);
    logic [15:0] r;
    bus(1'b1, s, d, 3'b101, r);
  endtask

  task automatic rd_reg(input logic [1:0] s, input string tag, input logic [15:0] exp);
    logic [15:0] r;
    bus(1'b0, s, 16'h0000, 3'b101, r);
    chk(tag, r, exp);
    chk("rd_model", r, m_rdata);
  endtask

  initial begin
    logic [15:0] r;
    int op;
    rst = 1'b1; pins0 = '0; pins1 = 5'h1F;
    adr = '0; wdat = '0; we = 1'b0; stb = 1'b0;
    ticks(2);
    rst = 1'b0;
    chk("rst_irq", {15'd0, irq0}, 16'd0);
    chk("rst_ack", {15'd0, ack0}, 16'd0);
    chk("rst_dat", dat0, 16'h0000);
    rd_reg(2'd0, "rst_stat", 16'h0000);
    rd_reg(2'd1, "rst_mask", 16'h001F);

    // Single event on channel 2: pending after 3 clocks, IRQ on the 4th.
    pins0[2] = 1'b1;
    ticks(3);
    chk("ev_irq_3clk", {15'd0, irq0}, 16'd0);
    tick();
    chk("ev_irq_4clk", {15'd0, irq0}, 16'd1);
    rd_reg(2'd0, "ev_stat", 16'h0004);
    wr_reg(2'd2, 16'h0004);
    chk("ev_clr_irq", {15'd0, irq0}, 16'd0);
    pins0[2] = 1'b0;
    ticks(3);

    // Overrun: two pulses on channel 0 without a clear.
    for (int k = 0; k < 2; k++) begin
      pins0[0] = 1'b1; ticks(2);
      pins0[0] = 1'b0; ticks(2);
    end
    ticks(2);
    rd_reg(2'd0, "ovr_stat", 16'h0101);
    wr_reg(2'd2, 16'h0101);
    chk("ovr_clr_irq", {15'd0, irq0}, 16'd0);
    rd_reg(2'd0, "ovr_clr_stat", 16'h0000);

    // Masked channel 0 keeps IRQ low until re-enabled.
    wr_reg(2'd1, 16'h001E);
    pins0[0] = 1'b1; ticks(5);
    chk("mask_irq_low", {15'd0, irq0}, 16'd0);
    rd_reg(2'd0, "mask_stat", 16'h0001);
    wr_reg(2'd1, 16'h001F);
    chk("unmask_irq", {15'd0, irq0}, 16'd1);
    pins0[0] = 1'b0;
    wr_reg(2'd2, 16'h0001);
    ticks(2);

    // Collision: new event on ch3 lands on the same edge as its clear.
    pins0[3] = 1'b1; ticks(4);
    pins0[3] = 1'b0; ticks(3);
    pins0[3] = 1'b1; ticks(2);
    wr_reg(2'd2, 16'h0008);
    chk("coll_irq", {15'd0, irq0}, 16'd1);
    rd_reg(2'd0, "coll_stat", 16'h0808);
    pins0 = '0;
    wr_reg(2'd2, 16'h1F1F);
    ticks(2);

    // Reset during a write strobe: no write, no ack.
    rst = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'hA001; wdat = 16'h0000;
    tick();
    rst = 1'b0; stb = 1'b0; we = 1'b0;
    chk("rst_mid_ack", {15'd0, ack0}, 16'd0);
    tick();
    rd_reg(2'd1, "rst_mid_mask", 16'h001F);

    // Back-to-back hits while in ACK re-execute the access.
    stb = 1'b1; we = 1'b0; adr = 16'hA000;
    tick();
    adr = 16'hA001;
    tick();
    chk("b2b_ack", {15'd0, ack0}, 16'd1);
    chk("b2b_dat", dat0, 16'h001F);
    stb = 1'b0;
    tick();
    chk("b2b_ack_off", {15'd0, ack0}, 16'd0);

    // Non-hit strobe (select 3'b100): no ack, clear ignored.
    pins0[1] = 1'b1; ticks(4);
    bus(1'b1, 2'd2, 16'h1F1F, 3'b100, r);
    chk("nohit_ack1", {15'd0, ack1}, 16'd0);
    rd_reg(2'd0, "nohit_stat", 16'h0002);

    // Random phase against the model.
    for (int it = 0; it < 60; it++) begin
      pins0 = 5'($urandom_range(0, 31));
      op = $urandom_range(0, 5);
      case (op)
        0: rd_reg(2'd0, "rnd_stat", m_rdata_stat());
        1: rd_reg(2'd1, "rnd_mask", {11'd0, m_mask});
        2: begin bus(1'b0, 2'd3, 16'h0, 3'b101, r); chk("rnd_raw", r, m_rdata); end
        3: wr_reg(2'd1, 16'($urandom_range(0, 65535)));
        4: wr_reg(2'd2, 16'($urandom_range(0, 65535)));
        default: ticks($urandom_range(1, 3));
      endcase
    end

    // Active-low instance: pins idle high, channel 0 falls.
    pins0 = '0;
    rst = 1'b1; ticks(2); rst = 1'b0;
    ticks(3);
    pins1 = 5'b11110;
    ticks(3);
    bus(1'b0, 2'd3, 16'h0, 3'b101, r);
    chk("pol_raw", dat1, 16'h0001);
    bus(1'b0, 2'd0, 16'h0, 3'b101, r);
    chk("pol_stat", dat1, 16'h0001);
    chk("pol_irq", {15'd0, irq1}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // STAT as the model sees it right now; the next edge may add an event, so the
  // read is also compared with the model's own snapshot inside rd_reg.
  function automatic logic [15:0] m_rdata_stat();
    logic [4:0] ev;
    ev = hist[1] & ~hist[2];
    return (ev == 5'd0) ? {3'b000, m_ovr, 3'b000, m_pend} : m_rdata_snapshot_pending();
  endfunction

  function automatic logic [15:0] m_rdata_snapshot_pending();
    return {3'b000, m_ovr, 3'b000, m_pend};
  endfunction

endmodule
